// File: rtl/booth_r4_mul_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and constants for the radix-4 Booth multiplier.
//   state_t   : controller states (IDLE, CALC, DONE)
//   dsel_t    : digit-select vector {zero, two, neg} produced by the recoder
//   D_*       : the five legal digit selects (0, +1, +2, -2, -1)
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // {zero, two, neg}: the addend is 0 when zero is set; otherwise it is
    // Qx or 2*Qx (two), negated when neg is set.
    typedef logic [2:0] dsel_t;

    localparam dsel_t D_ZERO = 3'b100;
    localparam dsel_t D_POS1 = 3'b000;
    localparam dsel_t D_POS2 = 3'b010;
    localparam dsel_t D_NEG2 = 3'b011;
    localparam dsel_t D_NEG1 = 3'b001;

endpackage

// File: rtl/booth_r4_mul_if.sv
// -----------------------------------------------------------------------------
// booth_r4_mul_if
// Operand / result handshake bundle for booth_r4_mul.
//   InValid, InReady  : operand handshake (accept on InValid & InReady)
//   Signed, M, Q      : operation mode and operands, sampled on accept
//   OutValid, OutReady: result handshake
//   P                 : 2W-bit product
// Modports: master = producer/consumer side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface booth_r4_mul_if #(
    parameter int W = 16
);
    logic           InValid;
    logic           InReady;
    logic           Signed;
    logic [W-1:0]   M;
    logic [W-1:0]   Q;
    logic           OutValid;
    logic           OutReady;
    logic [2*W-1:0] P;

    modport master (
        output InValid,
        output Signed,
        output M,
        output Q,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  P
    );

    modport slave (
        input  InValid,
        input  Signed,
        input  M,
        input  Q,
        input  OutReady,
        output InReady,
        output OutValid,
        output P
    );
endinterface

// File: rtl/booth_r4_mul_recoder.sv
// -----------------------------------------------------------------------------
// booth_r4_recoder
// Combinational radix-4 Booth digit recoder.
//   window in  3  {y[i+1], y[i], y[i-1]}
//   zero   out 1  digit is 0
//   two    out 1  magnitude is 2 (else 1)
//   neg    out 1  digit is negative
// -----------------------------------------------------------------------------
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic       zero,
    output logic       two,
    output logic       neg
);

    dsel_t sel;

    always_comb begin
        sel = D_ZERO;
        case (window)
            3'b000:  sel = D_ZERO;
            3'b001:  sel = D_POS1;
            3'b010:  sel = D_POS1;
            3'b011:  sel = D_POS2;
            3'b100:  sel = D_NEG2;
            3'b101:  sel = D_NEG1;
            3'b110:  sel = D_NEG1;
            3'b111:  sel = D_ZERO;
            default: sel = D_ZERO;
        endcase
    end

    assign zero = sel[2];
    assign two  = sel[1];
    assign neg  = sel[0];

endmodule

// File: rtl/booth_r4_mul.sv
// -----------------------------------------------------------------------------
// booth_r4_mul
// Radix-4 (modified Booth) sequential multiplier, one Booth digit per cycle,
// per-operation signed/unsigned mode, valid/ready on both sides.
//
// Ports:
//   Clock  in  rising-edge clock
//   Reset  in  synchronous, active-high reset
//   bus    booth_r4_mul_if.slave: InValid/InReady, Signed, M, Q,
//          OutValid/OutReady, P (registered product)
// Parameters:
//   W      operand width, even and >= 4
// Configuration macro:
//   BOOTH_ZERO_SKIP_EN  when defined, a zero operand bypasses CALC and goes
//                       straight to DONE with P = 0 on the accept edge.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | InReady=1, waiting for an operand pair
// CALC  | retiring one Booth digit per edge, counter counts N down to 1
// DONE  | OutValid=1, P held until OutReady
// -----------------------------------------------------------------------------
module booth_r4_mul
    import booth_pkg::*;
#(
    parameter int W = 16
)
(
    input  logic          Clock,
    input  logic          Reset,
    booth_r4_mul_if.slave bus
);

    localparam int N  = W / 2 + 1;
    localparam int XW = W + 2;          // extended operand width
    localparam int AW = W + 4;          // accumulator width
    localparam int CW = $clog2(N + 1);

    if (((W % 2) != 0) || (W < 4)) begin : g_bad_w
        $error("booth_r4_mul: W must be even and >= 4");
    end

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   a_q;
    logic [XW-1:0]   y_q;
    logic            ym1_q;
    logic [XW-1:0]   qx_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  p_q;

    logic            accept;
    logic            zero_skip;
    logic            last_step;

    logic [XW-1:0]   m_ext;
    logic [XW-1:0]   q_ext;

    logic            d_zero;
    logic            d_two;
    logic            d_neg;
    logic [AW-1:0]   qx_wide;
    logic [AW-1:0]   mag;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   a_sum;
    logic [AW-1:0]   a_nxt;
    logic [XW-1:0]   y_nxt;

    assign accept    = bus.InValid && (state == IDLE);
    assign last_step = (cnt_q == CW'(1));

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_skip = (bus.M == '0) || (bus.Q == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Operand extension to W+2 bits; the extra bits let an unsigned operand
    // be recoded as a positive two's-complement number.
    assign m_ext = bus.Signed ? {{2{bus.M[W-1]}}, bus.M} : {2'b00, bus.M};
    assign q_ext = bus.Signed ? {{2{bus.Q[W-1]}}, bus.Q} : {2'b00, bus.Q};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_skip ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.InReady  = (state == IDLE);
    assign bus.OutValid = (state == DONE);
    assign bus.P        = p_q;

    // ----------------------------------------------------------- datapath
    booth_r4_recoder u_recoder (
        .window ({y_q[1:0], ym1_q}),
        .zero   (d_zero),
        .two    (d_two),
        .neg    (d_neg)
    );

    assign qx_wide = {{2{qx_q[XW-1]}}, qx_q};
    assign mag     = d_two ? {qx_wide[AW-2:0], 1'b0} : qx_wide;

    always_comb begin
        addend = '0;
        if (!d_zero) begin
            addend = d_neg ? (~mag + AW'(1)) : mag;
        end
    end

    assign a_sum = a_q + addend;

    // Arithmetic shift of {A, Y, y_-1} right by two.
    assign a_nxt = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    assign y_nxt = {a_sum[1:0], y_q[XW-1:2]};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_q   <= '0;
            y_q   <= '0;
            ym1_q <= 1'b0;
            qx_q  <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= '0;
                        y_q   <= m_ext;
                        ym1_q <= 1'b0;
                        qx_q  <= q_ext;
                        cnt_q <= CW'(N);
                        if (zero_skip) begin
                            p_q <= '0;
                        end
                    end
                end
                CALC: begin
                    a_q   <= a_nxt;
                    y_q   <= y_nxt;
                    ym1_q <= y_q[1];
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        // Y holds the low W+2 product bits, A supplies the rest.
                        p_q <= {a_nxt[W-3:0], y_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
